// File: rtl/latch_write_ctrl_pkg.sv
// Shared definitions for the latch D/EN interface sequencers.
//   state_t      : 2-bit sequencer state (IDLE=0, SETUP=1, PULSE=2, HOLD=3)
//   DEF_*        : default data width and phase lengths
//   max3()       : helper for sizing phase counters
package latch_write_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_PULSE_CYC = 2;
    localparam int DEF_HOLD_CYC  = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/lwc_phase_cnt.sv
// Loadable down-counter with a zero flag, used to time sequencer phases.
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous, active-high reset (count -> 0)
//   load     in   1  load load_val on the next edge (wins over dec)
//   load_val in   W  value to load
//   dec      in   1  decrement by one on the next edge; saturates at 0
//   count    out  W  current count
//   zero     out  1  count == 0
module lwc_phase_cnt
    import latch_write_ctrl_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/latch_write_ctrl.sv
// Clocked driver for the D/EN write interface of a transparent latch bank.
// A word accepted over WR_VALID/WR_READY is put on D, then EN is pulsed
// with programmable setup, pulse and hold phases so D is stable around EN.
//   CLK       in   1      rising-edge clock
//   RST       in   1      asynchronous, active-high reset
//   WR_VALID  in   1      write request
//   WR_DATA   in   WIDTH  write word, sampled only on accept
//   WR_READY  out  1      high only in IDLE
//   D         out  WIDTH  latch data, registered
//   EN        out  1      latch enable, registered
//   BUSY      out  1      high in any state other than IDLE
//   DONE      out  1      one-cycle pulse in the last HOLD cycle
module latch_write_ctrl
    import latch_write_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_VALID,
    input  logic [WIDTH-1:0] WR_DATA,
    output logic             WR_READY,
    output logic [WIDTH-1:0] D,
    output logic             EN,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);

    generate
        if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_param
            $error("latch_write_ctrl: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
        end
    endgenerate

    state_t          state;
    logic            cnt_load;
    logic [CW-1:0]   cnt_load_val;
    logic            cnt_dec;
    logic [CW-1:0]   cnt;
    logic            cnt_zero;

    // Counter reloads on every phase transition, otherwise counts down.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state)
            IDLE: begin
                if (WR_VALID) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CW'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CW'(PULSE_CYC - 1);
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CW'(HOLD_CYC - 1);
                end
            end
            default: begin
                cnt_load     = 1'b0;
                cnt_load_val = '0;
            end
        endcase
        cnt_dec = !cnt_load && (state != IDLE);
    end

    lwc_phase_cnt #(
        .W (CW)
    ) u_phase_cnt (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // DONE is registered, so it is set on the edge that enters the last
    // HOLD cycle: either entering HOLD with a one-cycle hold, or counting
    // down from 1 to 0 inside HOLD.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            D     <= '0;
            EN    <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (WR_VALID) begin
                        D     <= WR_DATA;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_zero) begin
                        EN    <= 1'b1;
                        state <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt_zero) begin
                        EN    <= 1'b0;
                        state <= HOLD;
                        DONE  <= (HOLD_CYC == 1);
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        state <= IDLE;
                    end else begin
                        DONE <= (cnt == CW'(1));
                    end
                end
                default: begin
                    state <= IDLE;
                    EN    <= 1'b0;
                end
            endcase
        end
    end

    assign WR_READY = (state == IDLE);
    assign BUSY     = (state != IDLE);

endmodule
